// File: rtl/gate_sweep_pkg.sv
// Shared types and helpers for the gate sweep checker.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // Stimulus register plus two synchroniser flops must all settle before sampling.
  localparam int SETTLE_MIN = 3;

  function automatic int n_vec(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/gate_sweep_sync.sv
// Two-flop synchroniser for one asynchronous cell output.
module gate_sweep_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Walks every stimulus vector, samples each cell through a synchroniser and
// counts mismatches against a latched truth table, one counter per channel.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_CH   = 1,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       loop,
  input  logic [N_CH*n_vec(N_IN)-1:0] exp_tt,
  input  logic [N_CH-1:0]            resp,
  output logic [N_IN-1:0]            stim,
  output logic                       busy,
  output logic                       done,
  output logic                       valid,
  output logic [N_CH-1:0]            pass,
  output logic [N_CH*CNT_W-1:0]      err_cnt
);

  localparam int N_VEC = n_vec(N_IN);
  localparam int CW    = $clog2(SETTLE);

  if (SETTLE < SETTLE_MIN) begin : g_settle_chk
    $error("gate_sweep_checker: SETTLE is below the synchroniser settle minimum");
  end

  state_t                       state;
  logic [N_IN-1:0]              vector;
  logic [CW-1:0]                settle_cnt;
  logic [N_CH*N_VEC-1:0]        exp_q;
  logic [N_CH-1:0][CNT_W-1:0]   cnt;
  logic [N_CH-1:0]              sync_resp;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_sync
    gate_sweep_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (resp[ch]),
      .q   (sync_resp[ch])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      stim       <= '0;
      vector     <= '0;
      settle_cnt <= '0;
      exp_q      <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            exp_q      <= exp_tt;
            cnt        <= '0;
            valid      <= 1'b0;
            vector     <= '0;
            stim       <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == CW'(SETTLE - 1)) begin
            settle_cnt <= '0;
            state      <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        S_SAMPLE: begin
          // Counters stick at all-ones so a flood of errors never wraps to a pass.
          for (int ch = 0; ch < N_CH; ch++) begin
            if ((sync_resp[ch] != exp_q[ch*N_VEC + int'(vector)]) && (cnt[ch] != '1))
              cnt[ch] <= cnt[ch] + CNT_W'(1);
          end
          if (vector == N_IN'(N_VEC - 1)) begin
            done  <= 1'b1;
            valid <= 1'b1;
            state <= S_DONE;
          end else begin
            vector <= vector + N_IN'(1);
            stim   <= vector + N_IN'(1);
            state  <= S_SETTLE;
          end
        end
        S_DONE: begin
          if (loop) begin
            vector <= '0;
            stim   <= '0;
            state  <= S_SETTLE;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pass = '0;
    for (int ch = 0; ch < N_CH; ch++)
      pass[ch] = (cnt[ch] == '0);
  end

  assign err_cnt = cnt;

endmodule
